mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares one synchronous single-ported memory between the CPU datapath (requester 0) and a second bus master such as display/IO (requester 1). It latches the winning request, sequences the memory access through a small FSM, and returns a registered acknowledge with read data. It drives the datapath's address-select mux and capture-flop enables, so only one master touches the memory port per transaction.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  // Wide enough to hold READ_LATENCY-1 for latencies up to 4.
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory port arbiter.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic any_req,
  output logic winner
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    any_req = req0 | req1;
    winner  = REQ_CPU;
    if (req0 && req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      winner = ~last_grant;
`else
      winner = REQ_CPU;
`endif
    end else if (req1) begin
      winner = REQ_AUX;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-ported memory between two requesters.
// Tie-break policy set by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  grant,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(READ_LATENCY - 1);

  state_e                state_q;
  logic                  lat_we_q;
  logic [ADDR_WIDTH-1:0] lat_addr_q;
  logic [DATA_WIDTH-1:0] lat_wdata_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  last_grant_q;
  logic                  any_req;
  logic                  winner;

  mem_arb_pick u_pick (
    .req0      (req0),
    .req1      (req1),
    .last_grant(last_grant_q),
    .any_req   (any_req),
    .winner    (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata        <= '0;
      grant        <= REQ_CPU;
      busy         <= 1'b0;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      cnt_q        <= '0;
      last_grant_q <= REQ_AUX;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            grant        <= winner;
            last_grant_q <= winner;
            lat_we_q     <= winner ? we1 : we0;
            lat_addr_q   <= winner ? addr1 : addr0;
            lat_wdata_q  <= winner ? wdata1 : wdata0;
            busy         <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          if (lat_we_q) begin
            ack0    <= (grant == REQ_CPU);
            ack1    <= (grant == REQ_AUX);
            state_q <= StResp;
          end else begin
            cnt_q   <= CntLoad;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            rdata   <= mem_rdata;
            ack0    <= (grant == REQ_CPU);
            ack1    <= (grant == REQ_AUX);
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StResp: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gated with reset so an access in flight is suppressed in the reset cycle itself.
  assign mem_en    = (state_q == StIssue) & ~reset;
  assign mem_we    = mem_en & lat_we_q;
  assign mem_addr  = lat_addr_q;
  assign mem_wdata = lat_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: two instances (read latency 1 and 4),
// each attached to a behavioural memory, checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 16;
  localparam int          LAT0 = 1;
  localparam int          LAT1 = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         reset;
  logic [1:0]         req0, req1, we0, we1;
  logic [1:0][AW-1:0] addr0, addr1;
  logic [1:0][DW-1:0] wdata0, wdata1;
  logic [1:0]         ack0, ack1, grant, busy, mem_en, mem_we;
  logic [1:0][DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [1:0][AW-1:0] mem_addr;

  logic               tb_clear;
  logic [DW-1:0]      env_mem [2][256];
  logic [DW-1:0]      pipe    [2][4];

  int                 checks   = 0;
  int                 failures = 0;
  logic [DW-1:0]      ref_mem [2][256];
  logic [1:0][DW-1:0] exp_rdata;
  logic [1:0]         model_last;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT0)) dut0 (
    .clk(clk), .reset(reset[0]), .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
    .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
    .ack0(ack0[0]), .ack1(ack1[0]), .rdata(rdata[0]), .grant(grant[0]), .busy(busy[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT1)) dut1 (
    .clk(clk), .reset(reset[1]), .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
    .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
    .ack0(ack0[1]), .ack1(ack1[1]), .rdata(rdata[1]), .grant(grant[1]), .busy(busy[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // Synchronous memories; read data appears LAT cycles after the issue edge, junk otherwise.
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (tb_clear) begin
        for (int i = 0; i < 256; i++) env_mem[p][i] <= '0;
      end else if (mem_en[p] && mem_we[p]) begin
        env_mem[p][mem_addr[p][7:0]] <= mem_wdata[p];
      end
      pipe[p][0] <= (mem_en[p] && !mem_we[p]) ? env_mem[p][mem_addr[p][7:0]] : DW'($urandom);
      for (int i = 1; i < 4; i++) pipe[p][i] <= pipe[p][i-1];
    end
  end
  assign mem_rdata[0] = pipe[0][LAT0-1];
  assign mem_rdata[1] = pipe[1][LAT1-1];

  function automatic int lat_of(input int p);
    return (p == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int tie_winner(input logic last);
    if (RR) return last ? 0 : 1;
    return 0;
  endfunction

  // Cycles from request sampling (T) to the ack cycle.
  function automatic int ack_dist(input bit w, input int lat);
    return w ? 2 : 2 + lat;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return {8'($urandom), 5'd0, 3'($urandom_range(0, 7))};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input int r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    if (r == 0) begin
      req0[p] = 1'b1; we0[p] = w; addr0[p] = a; wdata0[p] = d;
    end else begin
      req1[p] = 1'b1; we1[p] = w; addr1[p] = a; wdata1[p] = d;
    end
  endtask

  task automatic drop_req(input int p, input int r);
    if (r == 0) req0[p] = 1'b0;
    else req1[p] = 1'b0;
  endtask

  // One round of up to two transactions starting in an idle cycle. When both requesters
  // are used and delay>0, requester late_r is raised at cycle `delay` (while busy).
  task automatic run_round(input int p, input bit [1:0] use_m, input int late_r,
                           input int delay_in, input bit [1:0] wv,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int lat, first_w, second, end_c, delay;
    int t_req[2], iss[2], ackc[2];
    logic [AW-1:0] av[2];
    logic [DW-1:0] dv[2];
    logic [1:0] e_ack;
    logic e_en, e_we, e_busy, e_grant;
    lat = lat_of(p);
    av[0] = a0; av[1] = a1; dv[0] = d0; dv[1] = d1;
    t_req[0] = 0; t_req[1] = 0;
    iss[0] = -1; iss[1] = -1; ackc[0] = -1; ackc[1] = -1;
    delay = delay_in;
    if (use_m == 2'b11 && delay == 0) first_w = tie_winner(model_last[p]);
    else if (use_m == 2'b11) first_w = 1 - late_r;
    else first_w = use_m[0] ? 0 : 1;
    model_last[p] = first_w[0];
    iss[first_w]  = 1;
    ackc[first_w] = ack_dist(wv[first_w], lat);
    end_c = ackc[first_w];
    if (use_m == 2'b11) begin
      second = 1 - first_w;
      if (delay > ackc[first_w]) delay = ackc[first_w];
      t_req[second] = delay;
      iss[second]   = ackc[first_w] + 2;
      ackc[second]  = ackc[first_w] + 1 + ack_dist(wv[second], lat);
      model_last[p] = second[0];
      end_c = ackc[second];
    end
    for (int r = 0; r < 2; r++)
      if (use_m[r] && t_req[r] == 0) set_req(p, r, wv[r], av[r], dv[r]);
    for (int c = 1; c <= end_c; c++) begin
      tick();
      e_ack = 2'b00; e_en = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_grant = 1'b0;
      for (int r = 0; r < 2; r++) begin
        if (use_m[r]) begin
          if (c == ackc[r]) begin
            e_ack[r] = 1'b1;
            if (!wv[r]) exp_rdata[p] = ref_mem[p][av[r][7:0]];
          end
          if (c == iss[r]) begin
            e_en = 1'b1; e_we = wv[r];
          end
          if (c >= iss[r] && c <= ackc[r]) begin
            e_busy = 1'b1; e_grant = (r == 1);
          end
        end
      end
      checks++;
      if ({ack1[p], ack0[p], mem_en[p], mem_we[p], busy[p]} !== {e_ack, e_en, e_we, e_busy}) begin
        failures++;
        $display("FAIL round_ctl p%0d c%0d: got ack1,ack0,en,we,busy=%b want %b", p, c,
                 {ack1[p], ack0[p], mem_en[p], mem_we[p], busy[p]}, {e_ack, e_en, e_we, e_busy});
      end
      checks++;
      if (rdata[p] !== exp_rdata[p]) begin
        failures++;
        $display("FAIL round_rdata p%0d c%0d: got %h want %h", p, c, rdata[p], exp_rdata[p]);
      end
      if (e_busy) begin
        checks++;
        if (grant[p] !== e_grant) begin
          failures++;
          $display("FAIL round_grant p%0d c%0d: got %b want %b", p, c, grant[p], e_grant);
        end
      end
      if (e_en) begin
        for (int r = 0; r < 2; r++) begin
          if (use_m[r] && c == iss[r]) begin
            checks++;
            if (mem_addr[p] !== av[r] || (wv[r] && mem_wdata[p] !== dv[r])) begin
              failures++;
              $display("FAIL round_issue p%0d c%0d: got addr %h data %h want addr %h data %h",
                       p, c, mem_addr[p], mem_wdata[p], av[r], dv[r]);
            end
          end
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (use_m[r] && c == ackc[r]) begin
          if (wv[r]) ref_mem[p][av[r][7:0]] = dv[r];
          drop_req(p, r);
        end
        if (use_m[r] && c == t_req[r]) set_req(p, r, wv[r], av[r], dv[r]);
      end
    end
    tick();
  endtask

  task automatic do_reset(input int p, input int cycles);
    reset[p] = 1'b1;
    req0[p] = 1'b0; req1[p] = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      checks++;
      if (mem_en[p] !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_en p%0d: got mem_en %b want 0", p, mem_en[p]);
      end
    end
    reset[p] = 1'b0;
    model_last[p] = 1'b1;
    exp_rdata[p] = '0;
  endtask

  task automatic test_reset();
    tb_clear = 1'b1;
    do_reset(0, 3);
    tb_clear = 1'b0;
    do_reset(1, 3);
    for (int i = 0; i < 10; i++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        checks++;
        if ({ack0[p], ack1[p], grant[p], busy[p], mem_en[p], mem_we[p]} !== 6'b0 ||
            rdata[p] !== '0 || mem_addr[p] !== '0 || mem_wdata[p] !== '0) begin
          failures++;
          $display("FAIL reset_idle p%0d c%0d: got ctl %b rdata %h addr %h wdata %h want all 0",
                   p, i, {ack0[p], ack1[p], grant[p], busy[p], mem_en[p], mem_we[p]},
                   rdata[p], mem_addr[p], mem_wdata[p]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    run_round(0, 2'b01, 0, 0, 2'b01, 16'h0010, '0, 16'hBEEF, '0);
    run_round(0, 2'b10, 0, 0, 2'b00, '0, 16'h0010, '0, '0);
    checks++;
    if (rdata[0] !== 16'hBEEF) begin
      failures++;
      $display("FAIL write_read p0: got %h want beef", rdata[0]);
    end
  endtask

  task automatic test_latency4();
    run_round(1, 2'b01, 0, 0, 2'b01, 16'h1234, '0, 16'h5A5A, '0);
    run_round(1, 2'b10, 0, 0, 2'b00, '0, 16'h1234, '0, '0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rdata[1] !== 16'h5A5A) begin
        failures++;
        $display("FAIL lat4_hold c%0d: got %h want 5a5a", i, rdata[1]);
      end
      tick();
    end
  endtask

  task automatic test_busy_arrival();
    run_round(0, 2'b10, 0, 0, 2'b10, '0, 16'h0020, '0, 16'h1357);
    // req1 raised at cycle 2, which is the WAIT cycle of req0's read.
    run_round(0, 2'b11, 1, 2, 2'b00, 16'h0010, 16'h0020, '0, '0);
  endtask

  // Both requesters hold reads continuously; after n acks the last winner drops.
  task automatic test_back_to_back(input int p, input int n, input logic [AW-1:0] a0,
                                   input logic [AW-1:0] a1);
    int lat, period, k, end_c;
    int w[$];
    logic last;
    logic [1:0] e_ack;
    logic [AW-1:0] av[2];
    av[0] = a0; av[1] = a1;
    lat = lat_of(p);
    period = 3 + lat;
    last = model_last[p];
    for (int i = 0; i < n; i++) begin
      w.push_back(tie_winner(last));
      last = w[i][0];
    end
    w.push_back(1 - w[n-1]);
    model_last[p] = w[n][0];
    end_c = 2 + lat + n * period;
    set_req(p, 0, 1'b0, a0, '0);
    set_req(p, 1, 1'b0, a1, '0);
    k = 0;
    for (int c = 1; c <= end_c; c++) begin
      tick();
      e_ack = 2'b00;
      if (k <= n && c == 2 + lat + k * period) begin
        e_ack[w[k]] = 1'b1;
        exp_rdata[p] = ref_mem[p][av[w[k]][7:0]];
      end
      checks++;
      if ({ack1[p], ack0[p]} !== e_ack) begin
        failures++;
        $display("FAIL b2b_ack p%0d c%0d: got ack1,ack0=%b want %b", p, c,
                 {ack1[p], ack0[p]}, e_ack);
      end
      checks++;
      if (rdata[p] !== exp_rdata[p]) begin
        failures++;
        $display("FAIL b2b_rdata p%0d c%0d: got %h want %h", p, c, rdata[p], exp_rdata[p]);
      end
      if (e_ack != 2'b00) begin
        if (k >= n - 1) drop_req(p, w[k]);
        k++;
      end
    end
    tick();
  endtask

  task automatic test_contention();
    run_round(0, 2'b01, 0, 0, 2'b01, 16'h0030, '0, 16'h2468, '0);
    test_back_to_back(0, 6, 16'h0010, 16'h0030);
    run_round(1, 2'b10, 0, 0, 2'b10, '0, 16'h0050, '0, 16'h0F0F);
    test_back_to_back(1, 3, 16'h1234, 16'h0050);
  endtask

  task automatic test_reset_in_issue();
    run_round(0, 2'b01, 0, 0, 2'b01, 16'h0040, '0, 16'h1111, '0);
    set_req(0, 0, 1'b1, 16'h0040, 16'h2222);
    tick();
    checks++;
    if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_issue_pre: got en,we=%b%b want 11", mem_en[0], mem_we[0]);
    end
    reset[0] = 1'b1;
    req0[0] = 1'b0;
    #1;
    checks++;
    if (mem_en[0] !== 1'b0 || mem_we[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_issue_gate: got en,we=%b%b want 00", mem_en[0], mem_we[0]);
    end
    tick();
    reset[0] = 1'b0;
    model_last[0] = 1'b1;
    exp_rdata[0] = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ack0[0], ack1[0], busy[0], grant[0], mem_en[0]} !== 5'b0 || rdata[0] !== '0 ||
          mem_addr[0] !== '0) begin
        failures++;
        $display("FAIL rst_issue_idle c%0d: got ctl %b rdata %h addr %h want 0", i,
                 {ack0[0], ack1[0], busy[0], grant[0], mem_en[0]}, rdata[0], mem_addr[0]);
      end
      tick();
    end
    checks++;
    if (env_mem[0][8'h40] !== 16'h1111) begin
      failures++;
      $display("FAIL rst_issue_mem: got %h want 1111", env_mem[0][8'h40]);
    end
    run_round(0, 2'b10, 0, 0, 2'b00, '0, 16'h0040, '0, '0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int p;
      p = (i % 4 == 3) ? 1 : 0;
      run_round(p, 2'($urandom_range(1, 3)), $urandom_range(0, 1),
                ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7), 2'($urandom),
                rand_addr(), rand_addr(), DW'($urandom), DW'($urandom));
    end
  endtask

  initial begin
    reset = 2'b11; tb_clear = 1'b1;
    req0 = '0; req1 = '0; we0 = '0; we1 = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    exp_rdata = '0; model_last = 2'b11;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 256; i++) ref_mem[p][i] = '0;
    test_reset();
    test_write_read();
    test_latency4();
    test_busy_arrival();
    test_contention();
    test_reset_in_issue();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
